rx_cmd_decoder: RTL
===================

// Module: rx_cmd_decoder
// PURPOSE
// - Downstream consumer of the bus synchronizer: takes synchronized UART RX bytes (sync_bus + 1-cycle valid pulse)
//   in the CLK domain, parses command frames, and drives the register file, ALU and TX return path.
// - Sits between the RX data synchronizer and RegFile/ALU; read/ALU results go out byte-wise toward the TX FIFO.
// PARAMETERS
// - DATA_WIDTH   8   byte width of rx_data, wr_data, rd_data, tx_data
// - ADDR_WIDTH   4   register file address width; address bytes are truncated to the low ADDR_WIDTH bits
// - FUN_WIDTH    4   ALU function code width; FUN bytes are truncated to the low FUN_WIDTH bits
// PORTS
// - CLK           in   1             system clock
// - RST           in   1             synchronous reset, active-low
// - rx_data       in   DATA_WIDTH    synchronized RX byte
// - rx_valid      in   1             one-cycle pulse; rx_data valid this cycle
// - wr_en         out  1             regfile write strobe (1 cycle)
// - rd_en         out  1             regfile read strobe (1 cycle)
// - addr          out  ADDR_WIDTH    regfile address for wr_en/rd_en
// - wr_data       out  DATA_WIDTH    regfile write data
// - rd_data       in   DATA_WIDTH    regfile read data
// - rd_valid      in   1             rd_data valid (1-cycle pulse)
// - alu_en        out  1             ALU start strobe (1 cycle)
// - alu_fun       out  FUN_WIDTH     ALU function code, held stable until result returns
// - clk_gate_en   out  1             ALU clock-gate enable
// - alu_out       in   2*DATA_WIDTH  ALU result
// - alu_valid     in   1             alu_out valid (1-cycle pulse)
// - tx_data       out  DATA_WIDTH    byte to transmit
// - tx_valid      out  1             tx_data valid; held until accepted
// - tx_ready      in   1             TX side accepts; transfer on tx_valid & tx_ready
// BEHAVIOUR
// - Clock: CLK only. Reset: RST synchronous, active-low. All outputs registered; reset value 0; FSM -> IDLE.
// - Frames (first byte = opcode, only in IDLE): 0xAA addr data | 0xBB addr | 0xCC opA opB fun | 0xDD fun.
// - IDLE: unknown opcode byte dropped, stay IDLE. Mid-frame, any byte (incl. 0xAA..0xDD) is payload.
// - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI.
// - 0xAA: addr latched; on data byte, next cycle wr_en=1 with addr/wr_data, -> IDLE.
// - 0xBB: on addr byte, next cycle rd_en=1 -> RD_WAIT; on rd_valid, tx_data=rd_data, tx_valid=1 -> TX_LO;
//   accept -> IDLE.
// - 0xCC: opA byte -> next cycle wr_en, addr=0; opB byte -> wr_en, addr=1; fun byte -> alu_en, ALU_WAIT.
// - 0xDD: fun byte -> next cycle alu_en=1, -> ALU_WAIT.
// - clk_gate_en: 1 from the alu_en cycle through the alu_valid cycle; 0 otherwise.
// - ALU_WAIT: on alu_valid latch alu_out; TX_LO sends alu_out[7:0], TX_HI sends alu_out[15:8].
//   Each byte is held until tx_ready, then -> IDLE.
// - Latency: strobe (wr_en/rd_en/alu_en) exactly 1 cycle after the rx_valid of the completing byte.
// - rx_valid during RD_WAIT/ALU_WAIT/TX_*: byte dropped; no state change. Never more than one strobe per cycle.
// - tx_data/tx_valid change only after acceptance. tx_valid & tx_ready in the same cycle as a new
//   result is impossible by construction.
// - rd_valid/alu_valid outside their wait state: ignored.
// - RST low mid-frame or mid-TX: abort frame, tx_valid drops next edge, no partial strobe issued.
// STRUCTURE
// - Shared package sys_cmd_pkg: opcode constants (CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC,
//   CMD_ALU_NOP=8'hDD), FSM state enum, OPA_ADDR=0, OPB_ADDR=1.
// - Optional sub-module tx_result_serializer: latches 1- or 2-byte result, runs valid/ready byte
//   sequencing LSB first.
// TESTING
// - AA 05 3C -> wr_en=1 one cycle, addr=5, wr_data=8'h3C, 1 cycle after 3rd rx_valid; FSM back in IDLE.
// - BB 07, rd_data=8'h5A on rd_valid, tx_ready=1 -> rd_en 1 cycle, addr=7; tx_data=5A once.
// - CC 12 34 00, alu_out=16'h0046 -> writes 12@0, 34@1, alu_en fun=0; tx bytes 46 then 00.
// - DD 02, tx_ready low for 5 cycles -> tx_valid held with 8'h..LO stable until tx_ready.
// - Unknown 0x11 in IDLE, then AA 01 FF -> 0x11 ignored; write FF@1.
// - AA 03, RST low one cycle, then 44 -> no wr_en; FSM IDLE, 0x44 dropped as unknown opcode.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_cmd_pkg
// Description : Shared command-frame definitions for the RX command decoder.
//               Opcodes, FSM state encoding and fixed ALU operand addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_cmd_pkg;

  // Opcode bytes; only recognised as the first byte of a frame
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots that receive the ALU operands of a CMD_ALU_OP frame
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // Decoder FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_WR_ADDR  = 4'd1;
  localparam state_t ST_WR_DATA  = 4'd2;
  localparam state_t ST_RD_ADDR  = 4'd3;
  localparam state_t ST_RD_WAIT  = 4'd4;
  localparam state_t ST_OPA      = 4'd5;
  localparam state_t ST_OPB      = 4'd6;
  localparam state_t ST_FUN      = 4'd7;
  localparam state_t ST_ALU_WAIT = 4'd8;
  localparam state_t ST_TX_LO    = 4'd9;
  localparam state_t ST_TX_HI    = 4'd10;

endpackage
`default_nettype wire

// File: rtl/rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rx_cmd_decoder
// Description : Parses synchronized UART RX bytes into register-file writes,
//               reads and ALU operations; returns results byte-wise (LSB
//               first) over a valid/ready TX interface. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_cmd_decoder
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_valid,
  output logic                    alu_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    clk_gate_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready
);

  state_t                  state_q,    state_d;
  logic                    wr_en_q,    wr_en_d;
  logic                    rd_en_q,    rd_en_d;
  logic                    alu_en_q,   alu_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q,  wr_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q,  alu_fun_d;
  logic                    cg_q,       cg_d;
  logic [DATA_WIDTH-1:0]   tx_data_q,  tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]   tx_hi_q,    tx_hi_d;
  logic                    tx_two_q,   tx_two_d;

  logic                    w_accept;
  assign w_accept = tx_valid_q & tx_ready;

  // Next-state logic: frame parsing, one-cycle strobes and result sequencing
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;
    cg_d       = cg_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_hi_d    = tx_hi_q;
    tx_two_d   = tx_two_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(CMD_WR))           state_d = ST_WR_ADDR;
          else if (rx_data == DATA_WIDTH'(CMD_RD))      state_d = ST_RD_ADDR;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_OPA;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_data;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_valid) begin
          rd_en_d = 1'b1;
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rd_valid) begin
          tx_data_d  = rd_data;
          tx_valid_d = 1'b1;
          tx_two_d   = 1'b0;
          state_d    = ST_TX_LO;
        end
      end
      ST_OPA: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_WIDTH'(OPA_ADDR);
          wr_data_d = rx_data;
          state_d   = ST_OPB;
        end
      end
      ST_OPB: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_WIDTH'(OPB_ADDR);
          wr_data_d = rx_data;
          state_d   = ST_FUN;
        end
      end
      ST_FUN: begin
        if (rx_valid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[FUN_WIDTH-1:0];
          cg_d      = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (alu_valid) begin
          cg_d       = 1'b0;
          tx_data_d  = alu_out[DATA_WIDTH-1:0];
          tx_hi_d    = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_two_d   = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (w_accept) begin
          if (tx_two_q) begin
            tx_data_d = tx_hi_q;
            state_d   = ST_TX_HI;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_TX_HI: begin
        if (w_accept) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      alu_fun_q  <= '0;
      cg_q       <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_hi_q    <= '0;
      tx_two_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      alu_fun_q  <= alu_fun_d;
      cg_q       <= cg_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_hi_q    <= tx_hi_d;
      tx_two_q   <= tx_two_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign alu_en      = alu_en_q;
  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign alu_fun     = alu_fun_q;
  assign clk_gate_en = cg_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;

endmodule
`default_nettype wire
